// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: states, opcodes, ALU codes, IR field positions and control word for the sequencer
package cpu_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_RESET = 4'd0;
    localparam state_t S_T0    = 4'd1;
    localparam state_t S_T1    = 4'd2;
    localparam state_t S_T2    = 4'd3;
    localparam state_t S_T3    = 4'd4;
    localparam state_t S_T4    = 4'd5;
    localparam state_t S_T5    = 4'd6;
    localparam state_t S_T6    = 4'd7;
    localparam state_t S_T7    = 4'd8;
    localparam state_t S_HALT  = 4'd9;

    typedef enum logic [3:0] {
        CL_RTYPE, CL_IMM, CL_MULDIV, CL_LD, CL_ST, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
    } cls_e;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_SHL  = 5'd5;
    localparam logic [4:0] OP_ROR  = 5'd6;
    localparam logic [4:0] OP_ROL  = 5'd7;
    localparam logic [4:0] OP_ADDI = 5'd8;
    localparam logic [4:0] OP_ANDI = 5'd9;
    localparam logic [4:0] OP_ORI  = 5'd10;
    localparam logic [4:0] OP_LD   = 5'd11;
    localparam logic [4:0] OP_ST   = 5'd12;
    localparam logic [4:0] OP_MUL  = 5'd13;
    localparam logic [4:0] OP_DIV  = 5'd14;
    localparam logic [4:0] OP_MFHI = 5'd15;
    localparam logic [4:0] OP_MFLO = 5'd16;
    localparam logic [4:0] OP_NOP  = 5'd17;
    localparam logic [4:0] OP_HALT = 5'd31;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SHR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_ROR = 4'd6;
    localparam logic [3:0] ALU_ROL = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;

    localparam int OP_LSB = 27;
    localparam int RA_LSB = 23;
    localparam int RB_LSB = 19;
    localparam int RC_LSB = 15;

    typedef struct packed {
        logic [3:0] reg_sel;
        logic [3:0] alu_select;
        logic       rin;
        logic       rout;
        logic       pc_out;
        logic       inc_pc;
        logic       ir_in;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       mdr_read;
        logic       y_in;
        logic       z_in;
        logic       zlow_out;
        logic       zhigh_out;
        logic       hi_in;
        logic       hi_out;
        logic       lo_in;
        logic       lo_out;
        logic       c_out;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: IR/memory inputs and datapath control outputs of the sequencer
interface control_sequencer_if;
    logic [31:0] ir;
    logic        mem_done;
    logic [3:0]  reg_sel;
    logic        rin, rout;
    logic        pc_out, inc_pc, ir_in, mar_in;
    logic        mdr_in, mdr_out, mdr_read;
    logic        y_in, z_in, zlow_out, zhigh_out, hi_in, hi_out, lo_in, lo_out, c_out;
    logic [3:0]  alu_select;
    logic        mem_read, mem_write;
    logic        run, mem_err;

    modport master (
        input  ir, mem_done,
        output reg_sel, rin, rout, pc_out, inc_pc, ir_in, mar_in, mdr_in, mdr_out, mdr_read,
               y_in, z_in, zlow_out, zhigh_out, hi_in, hi_out, lo_in, lo_out, c_out,
               alu_select, mem_read, mem_write, run, mem_err
    );

    modport slave (
        output ir, mem_done,
        input  reg_sel, rin, rout, pc_out, inc_pc, ir_in, mar_in, mdr_in, mdr_out, mdr_read,
               y_in, z_in, zlow_out, zhigh_out, hi_in, hi_out, lo_in, lo_out, c_out,
               alu_select, mem_read, mem_write, run, mem_err
    );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: maps an opcode to its execute class and ALU operation
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output cls_e       cls,
    output logic [3:0] alu_sel
);

    always_comb begin
        cls = CL_NOP;
        alu_sel = ALU_ADD;
        case (opcode)
            OP_ADDI: cls = CL_IMM;
            OP_ANDI: begin cls = CL_IMM; alu_sel = ALU_AND; end
            OP_ORI:  begin cls = CL_IMM; alu_sel = ALU_OR; end
            OP_LD:   cls = CL_LD;
            OP_ST:   cls = CL_ST;
            OP_MUL:  begin cls = CL_MULDIV; alu_sel = ALU_MUL; end
            OP_DIV:  begin cls = CL_MULDIV; alu_sel = ALU_DIV; end
            OP_MFHI: cls = CL_MFHI;
            OP_MFLO: cls = CL_MFLO;
            OP_HALT: cls = CL_HALT;
            default: if (opcode <= OP_ROL) begin cls = CL_RTYPE; alu_sel = opcode[3:0]; end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle Moore control FSM with memory-wait timeout for the bus datapath
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 255
)(
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus
);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_err_q, mem_err_d;
    cls_e       cls;
    logic [3:0] alu_sel, ra, rb, rc;
    logic       waiting, timeout, ir_unused;
    ctrl_t      c;

    assign ra = bus.ir[RA_LSB +: 4];
    assign rb = bus.ir[RB_LSB +: 4];
    assign rc = bus.ir[RC_LSB +: 4];
    assign ir_unused = ^bus.ir[RC_LSB-1:0];

    ctrl_decode u_decode (
        .opcode  (bus.ir[OP_LSB +: 5]),
        .cls     (cls),
        .alu_sel (alu_sel)
    );

    // Only these phases listen to mem_done; a phase gets MEM_WAIT_MAX+1 cycles before faulting
    assign waiting = state_q == S_T1 || (state_q == S_T6 && cls == CL_LD) || (state_q == S_T7 && cls == CL_ST);
    assign timeout = waiting && !bus.mem_done && wait_q == 8'(MEM_WAIT_MAX);
    assign wait_d = (waiting && !bus.mem_done && !timeout) ? wait_q + 8'd1 : 8'd0;
    assign mem_err_d = mem_err_q | timeout;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = bus.mem_done ? S_T2 : S_T1;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = cls == CL_HALT ? S_HALT : (cls inside {CL_MFHI, CL_MFLO, CL_NOP}) ? S_T0 : S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = (cls inside {CL_RTYPE, CL_IMM}) ? S_T0 : S_T6;
            S_T6:    state_d = cls == CL_MULDIV ? S_T0 : (cls == CL_LD && !bus.mem_done) ? S_T6 : S_T7;
            S_T7:    state_d = (cls == CL_ST && !bus.mem_done) ? S_T7 : S_T0;
            default: state_d = S_HALT;
        endcase
        if (timeout) state_d = S_HALT;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_RESET;
            wait_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q <= wait_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        c = '0;
        case (state_q)
            S_T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; end
            S_T1: begin c.mem_read = 1'b1; c.mdr_read = 1'b1; c.mdr_in = 1'b1; end
            S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
            S_T3: case (cls)
                CL_RTYPE, CL_IMM, CL_LD, CL_ST: begin c.rout = 1'b1; c.reg_sel = rb; c.y_in = 1'b1; end
                CL_MULDIV: begin c.rout = 1'b1; c.reg_sel = ra; c.y_in = 1'b1; end
                CL_MFHI:   begin c.hi_out = 1'b1; c.rin = 1'b1; c.reg_sel = ra; end
                CL_MFLO:   begin c.lo_out = 1'b1; c.rin = 1'b1; c.reg_sel = ra; end
                default: ;
            endcase
            S_T4: begin
                c.alu_select = alu_sel;
                c.z_in = 1'b1;
                c.rout = cls inside {CL_RTYPE, CL_MULDIV};
                c.c_out = cls inside {CL_IMM, CL_LD, CL_ST};
                c.reg_sel = cls == CL_RTYPE ? rc : cls == CL_MULDIV ? rb : 4'd0;
            end
            S_T5: begin
                c.zlow_out = 1'b1;
                c.rin = cls inside {CL_RTYPE, CL_IMM};
                c.reg_sel = c.rin ? ra : 4'd0;
                c.lo_in = cls == CL_MULDIV;
                c.mar_in = cls inside {CL_LD, CL_ST};
            end
            S_T6: case (cls)
                CL_MULDIV: begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
                CL_LD:     begin c.mem_read = 1'b1; c.mdr_read = 1'b1; c.mdr_in = 1'b1; end
                CL_ST:     begin c.rout = 1'b1; c.reg_sel = ra; c.mdr_in = 1'b1; end
                default: ;
            endcase
            S_T7: case (cls)
                CL_LD: begin c.mdr_out = 1'b1; c.rin = 1'b1; c.reg_sel = ra; end
                CL_ST: c.mem_write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

    assign bus.reg_sel    = c.reg_sel;
    assign bus.alu_select = c.alu_select;
    assign bus.rin        = c.rin;
    assign bus.rout       = c.rout;
    assign bus.pc_out     = c.pc_out;
    assign bus.inc_pc     = c.inc_pc;
    assign bus.ir_in      = c.ir_in;
    assign bus.mar_in     = c.mar_in;
    assign bus.mdr_in     = c.mdr_in;
    assign bus.mdr_out    = c.mdr_out;
    assign bus.mdr_read   = c.mdr_read;
    assign bus.y_in       = c.y_in;
    assign bus.z_in       = c.z_in;
    assign bus.zlow_out   = c.zlow_out;
    assign bus.zhigh_out  = c.zhigh_out;
    assign bus.hi_in      = c.hi_in;
    assign bus.hi_out     = c.hi_out;
    assign bus.lo_in      = c.lo_in;
    assign bus.lo_out     = c.lo_out;
    assign bus.c_out      = c.c_out;
    assign bus.mem_read   = c.mem_read;
    assign bus.mem_write  = c.mem_write;
    assign bus.run        = state_q != S_RESET && state_q != S_HALT;
    assign bus.mem_err    = mem_err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random instruction stream checked cycle by cycle against a per-instruction step list
module tb_control_sequencer;

    localparam int MAXW = 4;

    localparam logic [29:0] M_RIN   = 30'd1 << 21;
    localparam logic [29:0] M_ROUT  = 30'd1 << 20;
    localparam logic [29:0] M_PCO   = 30'd1 << 19;
    localparam logic [29:0] M_INC   = 30'd1 << 18;
    localparam logic [29:0] M_IRIN  = 30'd1 << 17;
    localparam logic [29:0] M_MAR   = 30'd1 << 16;
    localparam logic [29:0] M_MDRIN = 30'd1 << 15;
    localparam logic [29:0] M_MDRO  = 30'd1 << 14;
    localparam logic [29:0] M_MDRRD = 30'd1 << 13;
    localparam logic [29:0] M_YIN   = 30'd1 << 12;
    localparam logic [29:0] M_ZIN   = 30'd1 << 11;
    localparam logic [29:0] M_ZLO   = 30'd1 << 10;
    localparam logic [29:0] M_ZHI   = 30'd1 << 9;
    localparam logic [29:0] M_HIIN  = 30'd1 << 8;
    localparam logic [29:0] M_HIO   = 30'd1 << 7;
    localparam logic [29:0] M_LOIN  = 30'd1 << 6;
    localparam logic [29:0] M_LOO   = 30'd1 << 5;
    localparam logic [29:0] M_COUT  = 30'd1 << 4;
    localparam logic [29:0] M_MRD   = 30'd1 << 3;
    localparam logic [29:0] M_MWR   = 30'd1 << 2;
    localparam logic [29:0] M_RUN   = 30'd1 << 1;
    localparam logic [29:0] M_ERR   = 30'd1;

    logic clock = 1'b0;
    logic clear;
    int n_checks = 0;
    int n_pass = 0;
    logic [29:0] exp_q[$];
    bit md_q[$];
    logic [29:0] obs;

    control_sequencer_if bus();

    control_sequencer #(.MEM_WAIT_MAX(MAXW)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    assign obs = {bus.reg_sel, bus.alu_select, bus.rin, bus.rout, bus.pc_out, bus.inc_pc, bus.ir_in,
                  bus.mar_in, bus.mdr_in, bus.mdr_out, bus.mdr_read, bus.y_in, bus.z_in, bus.zlow_out,
                  bus.zhigh_out, bus.hi_in, bus.hi_out, bus.lo_in, bus.lo_out, bus.c_out,
                  bus.mem_read, bus.mem_write, bus.run, bus.mem_err};

    task automatic check(input string tag, input logic [29:0] got, input logic [29:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [29:0] rs(input logic [3:0] r);
        return 30'(r) << 26;
    endfunction

    function automatic logic [29:0] al(input logic [3:0] a);
        return 30'(a) << 22;
    endfunction

    function automatic bit nz();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic [29:0] v, input bit md);
        exp_q.push_back(v);
        md_q.push_back(md);
    endfunction

    // A memory phase lasts until mem_done, but never more than MAXW+1 cycles; 0 means it timed out
    function automatic bit mem_phase(input logic [29:0] v, input int delay);
        for (int k = 0; k <= MAXW; k++) begin
            push(v, k == delay);
            if (k == delay) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Expected per-cycle outputs of one instruction; returns 0 normal, 1 halt, 2 memory timeout
    function automatic int build(input logic [31:0] ins, input int d_fetch, input int d_mem);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = ins[31:27];
        ra = ins[26:23];
        rb = ins[22:19];
        rc = ins[18:15];
        push(M_RUN | M_PCO | M_MAR | M_INC, nz());
        if (!mem_phase(M_RUN | M_MRD | M_MDRRD | M_MDRIN, d_fetch)) return 2;
        push(M_RUN | M_MDRO | M_IRIN, nz());
        if (op <= 5'd7) begin
            push(M_RUN | M_ROUT | rs(rb) | M_YIN, nz());
            push(M_RUN | M_ROUT | rs(rc) | al(op[3:0]) | M_ZIN, nz());
            push(M_RUN | M_ZLO | M_RIN | rs(ra), nz());
        end else if (op >= 5'd8 && op <= 5'd10) begin
            push(M_RUN | M_ROUT | rs(rb) | M_YIN, nz());
            push(M_RUN | M_COUT | al(op == 5'd8 ? 4'd0 : op == 5'd9 ? 4'd2 : 4'd3) | M_ZIN, nz());
            push(M_RUN | M_ZLO | M_RIN | rs(ra), nz());
        end else if (op == 5'd13 || op == 5'd14) begin
            push(M_RUN | M_ROUT | rs(ra) | M_YIN, nz());
            push(M_RUN | M_ROUT | rs(rb) | al(op == 5'd13 ? 4'd8 : 4'd9) | M_ZIN, nz());
            push(M_RUN | M_ZLO | M_LOIN, nz());
            push(M_RUN | M_ZHI | M_HIIN, nz());
        end else if (op == 5'd11 || op == 5'd12) begin
            push(M_RUN | M_ROUT | rs(rb) | M_YIN, nz());
            push(M_RUN | M_COUT | M_ZIN, nz());
            push(M_RUN | M_ZLO | M_MAR, nz());
            if (op == 5'd11) begin
                if (!mem_phase(M_RUN | M_MRD | M_MDRRD | M_MDRIN, d_mem)) return 2;
                push(M_RUN | M_MDRO | M_RIN | rs(ra), nz());
            end else begin
                push(M_RUN | M_ROUT | rs(ra) | M_MDRIN, nz());
                if (!mem_phase(M_RUN | M_MWR, d_mem)) return 2;
            end
        end else if (op == 5'd15) push(M_RUN | M_HIO | M_RIN | rs(ra), nz());
        else if (op == 5'd16) push(M_RUN | M_LOO | M_RIN | rs(ra), nz());
        else begin
            push(M_RUN, nz());
            if (op == 5'd31) return 1;
        end
        return 0;
    endfunction

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'($urandom)};
    endfunction

    function automatic int rnd_delay();
        return ($urandom_range(0, 11) == 0) ? MAXW + 1 : int'($urandom_range(0, MAXW));
    endfunction

    task automatic run_queue(input string tag, input int n);
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            check(tag, obs, exp_q.pop_front());
            bus.mem_done = md_q.pop_front();
            @(posedge clock); #1;
        end
    endtask

    task automatic do_clear(input int n);
        clear = 1'b1;
        bus.mem_done = nz();
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            check("reset", obs, 30'd0);
        end
        clear = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic hold_halt(input int n, input bit err);
        for (int i = 0; i < n; i++) begin
            check(err ? "halt_err" : "halt", obs, err ? M_ERR : 30'd0);
            bus.mem_done = nz();
            @(posedge clock); #1;
        end
    endtask

    task automatic instr(input string tag, input logic [31:0] ins, input int d_fetch, input int d_mem, input int hold);
        int ret;
        bus.ir = ins;
        ret = build(ins, d_fetch, d_mem);
        run_queue(tag, 1000);
        if (ret != 0) begin
            hold_halt(hold, ret == 2);
            do_clear(1);
        end
    endtask

    logic [4:0] op_tab [22] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd31, 5'd20, 5'd25, 5'd30};

    initial begin
        bus.ir = 32'd0;
        bus.mem_done = 1'b0;
        do_clear(2);
        instr("add", 32'h0091_8000, 0, 0, 3);
        instr("ld_wait3", enc(5'd11, 4'd4, 4'd7, 4'd0), 0, 3, 3);
        instr("mul", enc(5'd13, 4'd5, 4'd6, 4'd0), 0, 0, 3);
        instr("fetch_timeout", enc(5'd0, 4'd1, 4'd2, 4'd3), 1000, 0, 3);
        instr("ld_wait_max", enc(5'd11, 4'd9, 4'd2, 4'd0), MAXW, MAXW, 3);
        instr("st_timeout", enc(5'd12, 4'd3, 4'd8, 4'd0), 1, MAXW + 1, 3);
        bus.ir = enc(5'd12, 4'd2, 4'd3, 4'd0);
        void'(build(bus.ir, 0, 0));
        run_queue("st_pre", 4);
        check("st_t4", obs, exp_q.pop_front());
        exp_q.delete();
        md_q.delete();
        do_clear(1);
        instr("halt", enc(5'd31, 4'd0, 4'd0, 4'd0), 0, 0, 20);
        for (int i = 0; i < 150; i++)
            instr("rand", enc(op_tab[$urandom_range(0, 21)], 4'($urandom), 4'($urandom), 4'($urandom)),
                  rnd_delay(), rnd_delay(), 3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
